// File: rtl/pmt_pkg.sv
// ============================================================================
// pmt_pkg : shared helpers for the pipelined mux tree.   Revision: 1.0
// ============================================================================
`default_nettype none

package pmt_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Digit k of a select index, where each digit is dig_w bits wide.
  function automatic logic [31:0] digit(input logic [31:0] sel, input int k, input int dig_w);
    return (sel >> (k * dig_w)) & ((32'd1 << dig_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_tree_stage.sv
// ============================================================================
// mux_tree_stage : one registered RADIX:1 level over GROUPS groups.  Rev 1.0
// ============================================================================
`default_nettype none

module mux_tree_stage
  import pmt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RADIX  = 4,
  parameter int GROUPS = 1,
  parameter int SEL_W  = 6,
  parameter int STAGE  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_i,
  input  logic                             valid_i,
  input  logic [RADIX*GROUPS*DATA_W-1:0]   data_i,
  input  logic [SEL_W-1:0]                 sel_i,
  output logic                             valid_o,
  output logic [GROUPS*DATA_W-1:0]         data_o,
  output logic [SEL_W-1:0]                 sel_o
);

  localparam int DIG_W = clog2(RADIX);

  logic [DIG_W-1:0]           dig;
  logic [GROUPS*DATA_W-1:0]   data_d;
  logic [GROUPS*DATA_W-1:0]   data_q;
  logic                       valid_q;
  logic [SEL_W-1:0]           sel_q;

  assign dig = DIG_W'(digit(32'(sel_i), STAGE, DIG_W));

  always_comb begin
    data_d = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int r = 0; r < RADIX; r++) begin
        if (dig == DIG_W'(r)) begin
          data_d[g*DATA_W +: DATA_W] = data_i[(g*RADIX + r)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      sel_q   <= sel_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

`default_nettype wire

// File: rtl/pipelined_mux_tree.sv
// ============================================================================
// pipelined_mux_tree : N:1 registered mux tree with valid/ready and auto-scan.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_mux_tree
  import pmt_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int RADIX  = 4,
  parameter  int LEVELS = 3,
  localparam int N      = RADIX ** LEVELS,
  localparam int DIG_W  = clog2(RADIX),
  localparam int SEL_W  = LEVELS * DIG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  scan_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [SEL_W-1:0]      out_idx
);

  logic             adv;
  logic             accept;
  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] scan_q;
  logic [SEL_W-1:0] scan_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign eff_sel  = scan_en ? scan_q : in_sel;

  // N is a power of two filling SEL_W exactly, so the natural rollover is the N-1 -> 0 wrap.
  always_comb begin
    scan_d = scan_q;
    if (accept && scan_en) begin
      scan_d = scan_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_d;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int GROUPS = RADIX ** (LEVELS - 1 - k);

    logic [RADIX*GROUPS*DATA_W-1:0] data_in;
    logic                           valid_in;
    logic [SEL_W-1:0]               sel_in;
    logic [GROUPS*DATA_W-1:0]       data_q;
    logic                           valid_q;
    logic [SEL_W-1:0]               sel_q;

    if (k == 0) begin : g_first
      assign data_in  = in_data;
      assign valid_in = in_valid;
      assign sel_in   = eff_sel;
    end else begin : g_next
      assign data_in  = g_stage[k-1].data_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sel_in   = g_stage[k-1].sel_q;
    end

    mux_tree_stage #(
      .DATA_W (DATA_W),
      .RADIX  (RADIX),
      .GROUPS (GROUPS),
      .SEL_W  (SEL_W),
      .STAGE  (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (adv),
      .valid_i (valid_in),
      .data_i  (data_in),
      .sel_i   (sel_in),
      .valid_o (valid_q),
      .data_o  (data_q),
      .sel_o   (sel_q)
    );
  end

  assign out_valid = g_stage[LEVELS-1].valid_q;
  assign out_data  = g_stage[LEVELS-1].data_q;
  assign out_idx   = g_stage[LEVELS-1].sel_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_mux_tree.sv
// ============================================================================
// tb_pipelined_mux_tree : scoreboard bench for pipelined_mux_tree.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_mux_tree;

  localparam int DATA_W = 8;
  localparam int RADIX  = 4;
  localparam int LEVELS = 3;
  localparam int N      = 64;
  localparam int SEL_W  = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]    in_sel;
  logic                scan_en;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [SEL_W-1:0]    out_idx;

  typedef struct packed {
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t             sb[$];
  int               pop_cyc[$];
  logic [SEL_W-1:0] scan_model;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;

  pipelined_mux_tree #(
    .DATA_W (DATA_W),
    .RADIX  (RADIX),
    .LEVELS (LEVELS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .scan_en   (scan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue side: push the expected word for every accept, tracking the scan index.
  always @(negedge clk) begin : p_issue
    logic [SEL_W-1:0] s;
    if (rst_n !== 1'b1) begin
      sb.delete();
      scan_model = '0;
    end else if (in_valid && in_ready) begin
      s = scan_en ? scan_model : in_sel;
      sb.push_back('{idx: s, data: (DATA_W'(s) ^ 8'hA5)});
      if (scan_en) scan_model = scan_model + SEL_W'(1);
    end
  end

  // Output side: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got idx 0x%0h data 0x%0h, no word outstanding", out_idx, out_data);
      end else begin
        e = sb.pop_front();
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_data", 32'(out_data), 32'(e.data));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin : p_main
    int lat;
    int p0;
    for (int i = 0; i < N; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'(i) ^ 8'hA5;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    scan_en   = 1'b0;
    out_ready = 1'b1;

    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single select of channel 37
    in_valid = 1'b1;
    in_sel   = 6'd37;
    tick();
    in_valid = 1'b0;
    in_sel   = '0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check("single_latency", 32'(lat), 32'd3);
    check("single_data", 32'(out_data), 32'h80);
    check("single_idx", 32'(out_idx), 32'd37);
    tick();
    check("single_after_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();

    // Streaming 0..63 back to back
    p0 = pop_cyc.size();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_sel   = SEL_W'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("stream_count", 32'(pop_cyc.size() - p0), 32'd64);
    if (pop_cyc.size() - p0 == 64)
      check("stream_no_gaps", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[p0]), 32'd63);

    // Backpressure with sel 5,6,7, then 9 offered during the stall
    p0 = pop_cyc.size();
    for (int i = 5; i <= 7; i++) begin
      in_valid = 1'b1;
      in_sel   = SEL_W'(i);
      tick();
    end
    check("bp_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    in_sel    = 6'd9;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'hA0);
      check("bp_hold_idx", 32'(out_idx), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("bp_count", 32'(pop_cyc.size() - p0), 32'd4);

    // Scan mode: in_sel held at 63, 66 accepts
    p0 = pop_cyc.size();
    scan_en  = 1'b1;
    in_sel   = 6'd63;
    in_valid = 1'b1;
    repeat (66) tick();
    in_valid = 1'b0;
    scan_en  = 1'b0;
    repeat (6) tick();
    check("scan_count", 32'(pop_cyc.size() - p0), 32'd66);

    // Mid-stream reset with 3 words in flight
    scan_en  = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data", 32'(out_data), 32'h00);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check("mrst_latency", 32'(lat), 32'd3);
    check("mrst_scan_idx", 32'(out_idx), 32'd0);
    check("mrst_scan_data", 32'(out_data), 32'hA5);
    scan_en = 1'b0;
    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
